// File: rtl/rattlesnake_instruction_fetch.sv
// Rattlesnake instruction fetch stage.
// Holds the program counter, issues single-outstanding word reads to
// instruction memory and hands each returned word to decode as a one-cycle
// enable_out strobe. Redirects (jump_valid / fetch_init) squash any read in
// flight; misaligned targets halt fetching and raise a level exception.
//
// Memory handshake: mem_read_en is a one-cycle request pulse carrying
// mem_read_addr, which stays stable until mem_read_ack. The ack returns
// mem_read_data and arrives at least one cycle after the request. Only one
// request is ever outstanding; an ack with nothing outstanding is ignored.
module rattlesnake_instruction_fetch #(
  parameter int                     PC_BITWIDTH = 32,
  parameter int                     XLEN        = 32,
  parameter logic [PC_BITWIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_reset,
  input  logic                   fetch_enable,
  input  logic                   fetch_init,
  input  logic [PC_BITWIDTH-1:0] start_addr,
  input  logic                   jump_valid,
  input  logic [PC_BITWIDTH-1:0] jump_addr,
  output logic                   mem_read_en,
  output logic [PC_BITWIDTH-3:0] mem_read_addr,
  input  logic                   mem_read_ack,
  input  logic [XLEN-1:0]        mem_read_data,
  output logic                   enable_out,
  output logic [XLEN-1:0]        IR_out,
  output logic [PC_BITWIDTH-1:0] PC_out,
  output logic                   exception_addr_misaligned,
  output logic [1:0]             fetch_state_dbg
);

  // IDLE: nothing outstanding; WAIT: read outstanding, deliver it;
  // DROP: read outstanding, discard it (a redirect arrived meanwhile).
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]             state_q,  state_d;
  logic [PC_BITWIDTH-1:0] pc_q,     pc_d;
  logic [XLEN-1:0]        ir_q,     ir_d;
  logic [PC_BITWIDTH-1:0] pc_out_q, pc_out_d;
  logic                   en_out_q, en_out_d;
  logic                   rd_en_q,  rd_en_d;
  logic [PC_BITWIDTH-3:0] rd_addr_q, rd_addr_d;

  logic                   redirect;
  logic [PC_BITWIDTH-1:0] redirect_pc;
  logic [PC_BITWIDTH-1:0] pc_plus4;
  logic                   pc_aligned;

  // Redirect target selection (fetch_init has priority) and sequential PC.
  always_comb begin
    redirect    = fetch_init | jump_valid;
    redirect_pc = fetch_init ? start_addr : jump_addr;
    pc_plus4    = pc_q + PC_BITWIDTH'(4);
    pc_aligned  = (pc_q[1:0] == 2'b00);
  end

  // Fetch FSM, PC update, request generation and decode hand-off.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pc_out_d  = pc_out_q;
    en_out_d  = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (fetch_enable && pc_aligned) begin
          state_d   = S_WAIT;
          rd_en_d   = 1'b1;
          rd_addr_d = pc_q[PC_BITWIDTH-1:2];
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // Data arriving together with a redirect belongs to the old path.
          pc_d    = redirect_pc;
          state_d = mem_read_ack ? S_IDLE : S_DROP;
        end else if (mem_read_ack) begin
          ir_d     = mem_read_data;
          pc_out_d = pc_q;
          en_out_d = 1'b1;
          pc_d     = pc_plus4;
          if (fetch_enable) begin
            rd_en_d   = 1'b1;
            rd_addr_d = pc_plus4[PC_BITWIDTH-1:2];
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (mem_read_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Synchronous reset has exactly the effect of the asynchronous one.
    if (sync_reset) begin
      state_d   = S_IDLE;
      pc_d      = RESET_PC;
      ir_d      = '0;
      pc_out_d  = '0;
      en_out_d  = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = RESET_PC[PC_BITWIDTH-1:2];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      pc_out_q  <= '0;
      en_out_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= RESET_PC[PC_BITWIDTH-1:2];
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pc_out_q  <= pc_out_d;
      en_out_q  <= en_out_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Outputs; the exception is a level while fetch is parked on a bad PC.
  always_comb begin
    mem_read_en               = rd_en_q;
    mem_read_addr             = rd_addr_q;
    enable_out                = en_out_q;
    IR_out                    = ir_q;
    PC_out                    = pc_out_q;
    exception_addr_misaligned = (state_q == S_IDLE) && (pc_q[1:0] != 2'b00);
    fetch_state_dbg           = state_q;
  end

endmodule
